fetch_stage: RTL and testbench

- Upstream neighbour of the 16-bit byte-addressed instruction memory.
- Owns the program counter (PC) and drives the memory address.
- Captures the returned 16-bit instruction into the IF/ID pipeline register, together with PC+2 and a valid bit.
- Handles stall, explicit flush and taken-branch/jump redirect from the hazard and branch logic.

---
 rtl/mips16_pkg.sv | 34 +++
 rtl/fetch_stage_if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// -----------------------------------------------------------------------------
// mips16_pkg
//   Constants and types shared by the 16-bit pipeline stages.
//
//   ADDR_W     PC / instruction memory byte-address width
//   INSTR_W    instruction width
//   NOP_INSTR  bubble encoding (add $0,$0,$0)
//   PC_STEP    bytes per instruction
//   if_id_t    IF/ID pipeline register contents. The fetch stage writes it
//              and the decode stage reads it.
// -----------------------------------------------------------------------------
package mips16_pkg;

  localparam int unsigned       ADDR_W    = 16;
  localparam int unsigned       INSTR_W   = 16;
  localparam int unsigned       PC_STEP   = 2;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  pc_plus2;
    logic               valid;
  } if_id_t;

  // Value the IF/ID register holds after reset or when squashed.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.instruction = NOP_INSTR;
    b.pc_plus2    = '0;
    b.valid       = 1'b0;
    return b;
  endfunction

endpackage : mips16_pkg

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register with bubble/hold/load control.
//   Priority on each rising edge: rst, then bubble, then hold, then load.
//
//   clk       system clock
//   rst       synchronous active-high reset; loads a bubble
//   bubble_i  squash the register contents (flush or redirect)
//   hold_i    keep the current contents (stall)
//   load_i    contents to capture on a normal fetch
//   q_o       registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_reg
  import mips16_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   bubble_i,
  input  logic   hold_i,
  input  if_id_t load_i,
  output if_id_t q_o
);

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = load_i;
    if (bubble_i) begin
      q_d = if_id_bubble();
    end else if (hold_i) begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= if_id_bubble();
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch. It owns the PC, addresses the combinational instruction
//   memory and captures the returned word into the IF/ID register along with
//   PC+2 and a valid bit. It reacts to stall, flush and branch/jump redirect.
//
//   clk                system clock
//   rst                synchronous active-high reset (overrides all inputs)
//   stall              hold PC and IF/ID
//   flush              squash IF/ID
//   redirect           taken branch/jump. PC <= aligned target, IF/ID squashed
//   redirect_target    new PC. Bit 0 is ignored.
//   imem_address       instruction memory address (= pc, combinational)
//   imem_instruction   instruction memory read data (same cycle)
//   if_id_instruction  registered instruction for decode
//   if_id_pc_plus2     registered PC+2 of that instruction
//   if_id_valid        IF/ID holds a real instruction
//   pc                 current PC
//
//   Optional build macro FETCH_PERF_CNT_EN adds the following outputs:
//   fetch_count        edges that loaded a valid instruction (wraps at 2^32)
//   bubble_count       non-reset edges that loaded a bubble or held on stall
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned       ADDR_W    = mips16_pkg::ADDR_W,
  parameter int unsigned       INSTR_W   = mips16_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = mips16_pkg::NOP_INSTR,
  parameter int unsigned       PC_STEP   = mips16_pkg::PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        bubble_count
`endif
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_plus2;
  logic              squash;
  logic              load_en;

  mips16_pkg::if_id_t if_id_load;
  mips16_pkg::if_id_t if_id_q;

  // Wraps modulo 2^ADDR_W. There is no overflow flag.
  assign pc_plus2 = pc_q + ADDR_W'(PC_STEP);

  // A redirect outranks a stall: the branch target is fetched and the
  // instruction fetched this cycle is from the wrong path.
  always_comb begin
    pc_d = pc_plus2;
    if (redirect) begin
      pc_d = {redirect_target[ADDR_W-1:1], 1'b0};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc           = pc_q;
  assign imem_address = pc_q;

  assign squash  = flush | redirect;
  assign load_en = ~squash & ~stall;

  always_comb begin
    if_id_load             = '0;
    if_id_load.instruction = imem_instruction;
    if_id_load.pc_plus2    = pc_plus2;
    if_id_load.valid       = 1'b1;
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (squash),
    .hold_i   (stall),
    .load_i   (if_id_load),
    .q_o      (if_id_q)
  );

  assign if_id_instruction = if_id_q.instruction;
  assign if_id_pc_plus2    = if_id_q.pc_plus2;
  assign if_id_valid       = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // A non-reset edge either loads a real instruction or squashes or holds.
  // Exactly one of the two counters advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (load_en) begin
      fetch_cnt_q  <= fetch_cnt_q + 32'd1;
    end else begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic [15:0] imem_address;
  logic [15:0] imem_instruction;
  logic [15:0] if_id_instruction;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic [15:0] pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  logic [15:0] mem [0:32767];
  assign imem_instruction = mem[imem_address[15:1]];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .redirect          (redirect),
    .redirect_target   (redirect_target),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus2    (if_id_pc_plus2),
    .if_id_valid       (if_id_valid),
    .pc                (pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count       (fetch_count),
    .bubble_count      (bubble_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: what the fetch stage should hold after each edge.
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_instr = 16'h0000;
  logic [15:0] m_pp2   = 16'h0000;
  logic        m_vld   = 1'b0;
  logic [31:0] m_fetch = 32'd0;
  logic [31:0] m_bub   = 32'd0;
  bit          m_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive the inputs, predict the result, then compare it after the edge.
  task automatic step(input bit r, input bit st, input bit fl, input bit rd, input logic [15:0] tgt);
    logic [15:0] fetched;
    logic [15:0] seq_pc;
    @(negedge clk);
    rst = r; stall = st; flush = fl; redirect = rd; redirect_target = tgt;
    #1;
    if (m_known) chk("imem_address", {16'h0, imem_address}, {16'h0, m_pc});
    fetched = mem[m_pc / 2];
    seq_pc  = 16'((32'(m_pc) + 32'd2) % 32'd65536);
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000; m_vld = 1'b0;
      m_fetch = 32'd0; m_bub = 32'd0; m_known = 1'b1;
    end else begin
      if (fl || rd) begin
        m_instr = 16'h0000; m_pp2 = 16'h0000; m_vld = 1'b0; m_bub = m_bub + 32'd1;
      end else if (st) begin
        m_bub = m_bub + 32'd1;
      end else begin
        m_instr = fetched; m_pp2 = seq_pc; m_vld = 1'b1; m_fetch = m_fetch + 32'd1;
      end
      if (rd)      m_pc = 16'((tgt / 16'd2) * 16'd2);
      else if (!st) m_pc = seq_pc;
    end
    @(posedge clk);
    #1;
    chk("pc", {16'h0, pc}, {16'h0, m_pc});
    chk("if_id_instruction", {16'h0, if_id_instruction}, {16'h0, m_instr});
    chk("if_id_pc_plus2", {16'h0, if_id_pc_plus2}, {16'h0, m_pp2});
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_vld});
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_fetch);
    chk("bubble_count", bubble_count, m_bub);
`endif
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hE188;
    mem[1] = 16'h0000;

    // Reset
    step(1, 0, 0, 0, 16'h0);
    step(1, 1, 1, 1, 16'h1234);
    chk("reset_pc", {16'h0, pc}, 32'h0000);
    chk("reset_valid", {31'h0, if_id_valid}, 32'h0);
    chk("reset_instr", {16'h0, if_id_instruction}, 32'h0000);
    chk("reset_pp2", {16'h0, if_id_pc_plus2}, 32'h0000);

    // Free run: the first edge captures the word at address 0
    step(0, 0, 0, 0, 16'h0);
    chk("first_instr", {16'h0, if_id_instruction}, 32'hE188);
    chk("first_pp2", {16'h0, if_id_pc_plus2}, 32'h0002);
    chk("first_valid", {31'h0, if_id_valid}, 32'h1);
    chk("first_pc", {16'h0, pc}, 32'h0002);
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    chk("pc_at_6", {16'h0, pc}, 32'h0006);

    // Stall three cycles at pc=6, then release
    step(0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);
    chk("stall_pc", {16'h0, pc}, 32'h0006);
    chk("stall_pp2_hold", {16'h0, if_id_pc_plus2}, 32'h0006);
    step(0, 0, 0, 0, 16'h0);
    chk("release_pc", {16'h0, pc}, 32'h0008);
    step(0, 0, 0, 0, 16'h0);

    // Redirect at pc=10
    step(0, 0, 0, 1, 16'h0020);
    chk("redir_pc", {16'h0, pc}, 32'h0020);
    chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
    chk("redir_instr", {16'h0, if_id_instruction}, 32'h0000);
    step(0, 0, 0, 0, 16'h0);
    chk("after_redir_instr", {16'h0, if_id_instruction}, {16'h0, mem[16]});

    // Redirect together with stall to an odd target
    step(0, 1, 0, 1, 16'h0031);
    chk("redir_stall_pc", {16'h0, pc}, 32'h0030);
    chk("redir_stall_valid", {31'h0, if_id_valid}, 32'h0);

    // Flush with stall, then flush alone
    step(0, 0, 0, 0, 16'h0);
    step(0, 1, 1, 0, 16'h0);
    chk("flush_stall_pc", {16'h0, pc}, 32'h0032);
    step(0, 0, 1, 0, 16'h0);

    // PC wraps at the top of the address space
    step(0, 0, 0, 1, 16'hFFFE);
    step(0, 0, 0, 0, 16'h0);
    chk("wrap_pc", {16'h0, pc}, 32'h0000);
    chk("wrap_pp2", {16'h0, if_id_pc_plus2}, 32'h0000);

    // Reset discards a simultaneous redirect
    step(0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 1, 16'h4444);
    chk("rst_redir_pc", {16'h0, pc}, 32'h0000);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 60) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
           ($urandom % 8) == 0, 16'($urandom));
    end

    // Counter scenario: 5 fetches, 2 stall cycles, 1 flush
    step(1, 0, 0, 0, 16'h0);
    for (int n = 0; n < 5; n++) step(0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", fetch_count, 32'd5);
    chk("perf_bubble", bubble_count, 32'd3);
    step(1, 0, 0, 0, 16'h0);
    chk("perf_fetch_rst", fetch_count, 32'd0);
    chk("perf_bubble_rst", bubble_count, 32'd0);
`else
    chk("scenario_pc", {16'h0, pc}, 32'h000C);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_stage
